// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall/flush/forward control for the 5-stage core (optional counters: HAZARD_PERF_CNT_EN)
module hazard_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdD_i,
  input  logic                      reg_writeD_i,
  input  logic [1:0]                result_srcD_i,
  input  logic                      pc_srcE_i,
  output logic                      stallF_o,
  output logic                      stallD_o,
  output logic                      flushD_o,
  output logic                      flushE_o,
  output logic [1:0]                forward_aE_o,
  output logic [1:0]                forward_bE_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
`endif
);

  localparam logic [REG_ADDR_WIDTH-1:0] X0 = '0;

  // Shadow pipeline: E carries sources too, M and W only the destination
  logic [REG_ADDR_WIDTH-1:0] e_rs1_q, e_rs1_d;
  logic [REG_ADDR_WIDTH-1:0] e_rs2_q, e_rs2_d;
  logic [REG_ADDR_WIDTH-1:0] e_rd_q,  e_rd_d;
  logic                      e_rw_q,  e_rw_d;
  logic                      e_ld_q,  e_ld_d;
  logic [REG_ADDR_WIDTH-1:0] m_rd_q,  m_rd_d;
  logic                      m_rw_q,  m_rw_d;
  logic [REG_ADDR_WIDTH-1:0] w_rd_q,  w_rd_d;
  logic                      w_rw_q,  w_rw_d;

  logic       lw_stall;
  logic       stall_int;
  logic       flush_e_int;
  logic [1:0] fwd_a_int;
  logic [1:0] fwd_b_int;

  // Youngest producer wins: M before W, and x0 is never a real producer
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic [REG_ADDR_WIDTH-1:0] m_rd,
    input logic                      m_rw,
    input logic [REG_ADDR_WIDTH-1:0] w_rd,
    input logic                      w_rw
  );
    if (m_rw && (m_rd != X0) && (m_rd == rs)) begin
      return 2'b10;
    end else if (w_rw && (w_rd != X0) && (w_rd == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Hazard detection; a redirect overrides a load-use stall since decode is on the wrong path
  always_comb begin
    lw_stall    = e_ld_q && (e_rd_q != X0) && ((e_rd_q == rs1D_i) || (e_rd_q == rs2D_i));
    stall_int   = lw_stall && !pc_srcE_i;
    flush_e_int = lw_stall || pc_srcE_i;
    fwd_a_int   = fwd_sel(e_rs1_q, m_rd_q, m_rw_q, w_rd_q, w_rw_q);
    fwd_b_int   = fwd_sel(e_rs2_q, m_rd_q, m_rw_q, w_rd_q, w_rw_q);
  end

  // Outputs are forced quiet while reset is held
  always_comb begin
    stallF_o     = rst_ni && stall_int;
    stallD_o     = rst_ni && stall_int;
    flushD_o     = rst_ni && pc_srcE_i;
    flushE_o     = rst_ni && flush_e_int;
    forward_aE_o = rst_ni ? fwd_a_int : 2'b00;
    forward_bE_o = rst_ni ? fwd_b_int : 2'b00;
  end

  // Next shadow state: advance M/W, and load E from decode unless it is flushed to a bubble
  always_comb begin
    w_rd_d  = m_rd_q;
    w_rw_d  = m_rw_q;
    m_rd_d  = e_rd_q;
    m_rw_d  = e_rw_q;
    e_rs1_d = '0;
    e_rs2_d = '0;
    e_rd_d  = '0;
    e_rw_d  = 1'b0;
    e_ld_d  = 1'b0;
    if (!flush_e_int) begin
      e_rs1_d = rs1D_i;
      e_rs2_d = rs2D_i;
      e_rd_d  = rdD_i;
      e_rw_d  = reg_writeD_i;
      e_ld_d  = (result_srcD_i == 2'b01);
    end
  end

  // Shadow state register; reset turns every stage into a bubble
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      e_rs1_q <= '0;
      e_rs2_q <= '0;
      e_rd_q  <= '0;
      e_rw_q  <= 1'b0;
      e_ld_q  <= 1'b0;
      m_rd_q  <= '0;
      m_rw_q  <= 1'b0;
      w_rd_q  <= '0;
      w_rw_q  <= 1'b0;
    end else begin
      e_rs1_q <= e_rs1_d;
      e_rs2_q <= e_rs2_d;
      e_rd_q  <= e_rd_d;
      e_rw_q  <= e_rw_d;
      e_ld_q  <= e_ld_d;
      m_rd_q  <= m_rd_d;
      m_rw_q  <= m_rw_d;
      w_rd_q  <= w_rd_d;
      w_rw_q  <= w_rw_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters for stall cycles and redirects
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_int && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (pc_srcE_i && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - table-driven scoreboard bench for hazard_unit
module tb_hazard_unit;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [4:0] rs1D_i, rs2D_i, rdD_i;
  logic       reg_writeD_i;
  logic [1:0] result_srcD_i;
  logic       pc_srcE_i;
  logic       stallF_o, stallD_o, flushD_o, flushE_o;
  logic [1:0] forward_aE_o, forward_bE_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  hazard_unit #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rs1D_i        (rs1D_i),
    .rs2D_i        (rs2D_i),
    .rdD_i         (rdD_i),
    .reg_writeD_i  (reg_writeD_i),
    .result_srcD_i (result_srcD_i),
    .pc_srcE_i     (pc_srcE_i),
    .stallF_o      (stallF_o),
    .stallD_o      (stallD_o),
    .flushD_o      (flushD_o),
    .flushE_o      (flushE_o),
    .forward_aE_o  (forward_aE_o),
    .forward_bE_o  (forward_bE_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  typedef struct {
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       rw;
    logic [1:0] src;
    logic       pc;
    logic       sf, sd, fd, fe;
    logic [1:0] fa, fb;
  } vec_t;

  localparam int NVEC = 33;
  vec_t vecs[NVEC];
  vec_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int unsigned exp_stall_cnt = 0;
  int unsigned exp_flush_cnt = 0;

  function automatic vec_t mk(input logic r, input int rs1, input int rs2, input int rd,
                              input logic rw, input logic [1:0] src, input logic pc,
                              input logic sf, input logic sd, input logic fd, input logic fe,
                              input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.rst_n = r;   v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.rw = rw;     v.src = src;     v.pc = pc;
    v.sf = sf;     v.sd = sd;       v.fd = fd;       v.fe = fe;
    v.fa = fa;     v.fb = fb;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: actual=%0h required=%0h", name, idx, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_ni        = v.rst_n;
    rs1D_i        = v.rs1;
    rs2D_i        = v.rs2;
    rdD_i         = v.rd;
    reg_writeD_i  = v.rw;
    result_srcD_i = v.src;
    pc_srcE_i     = v.pc;
    exp_q.push_back(v);
  endtask

  task automatic sample(input int idx);
    vec_t v;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", idx, 32'd1, 32'd0);
      return;
    end
    v = exp_q.pop_front();
    chk("stallF", idx, 32'(stallF_o), 32'(v.sf));
    chk("stallD", idx, 32'(stallD_o), 32'(v.sd));
    chk("flushD", idx, 32'(flushD_o), 32'(v.fd));
    chk("flushE", idx, 32'(flushE_o), 32'(v.fe));
    chk("fwdA", idx, 32'(forward_aE_o), 32'(v.fa));
    chk("fwdB", idx, 32'(forward_bE_o), 32'(v.fb));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", idx, stall_cnt_o, exp_stall_cnt);
    chk("flush_cnt", idx, flush_cnt_o, exp_flush_cnt);
    if (!v.rst_n) begin
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
    end else begin
      if (v.sd) exp_stall_cnt++;
      if (v.pc) exp_flush_cnt++;
    end
`endif
  endtask

  task automatic step(input vec_t v, input int idx);
    drive(v);
    @(negedge clk_i);
    sample(idx);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    //            rst rs1 rs2 rd rw src   pc   sF sD fD fE fa     fb
    vecs[0]  = mk(0,  5,  5,  5, 1, 2'b01, 1,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[1]  = mk(0,  3,  7,  9, 1, 2'b00, 1,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[2]  = mk(0,  1,  2,  3, 0, 2'b01, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[3]  = mk(1,  0,  0,  0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[4]  = mk(1,  1,  2,  5, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[5]  = mk(1,  5,  6,  8, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[6]  = mk(1,  9,  5, 10, 1, 2'b00, 0,  0, 0, 0, 0, 2'b10, 2'b00);
    vecs[7]  = mk(1,  0,  0,  0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b01);
    vecs[8]  = mk(1,  0,  0,  7, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[9]  = mk(1,  1,  1,  7, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[10] = mk(1,  7,  7,  0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[11] = mk(1,  0,  0,  0, 1, 2'b00, 0,  0, 0, 0, 0, 2'b10, 2'b10);
    vecs[12] = mk(1,  3,  4,  0, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[13] = mk(1,  0,  0,  1, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[14] = mk(1,  0,  0,  0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[15] = mk(1,  2,  0,  3, 1, 2'b01, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[16] = mk(1,  4,  3,  6, 1, 2'b00, 0,  1, 1, 0, 1, 2'b00, 2'b00);
    vecs[17] = mk(1,  4,  3,  6, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[18] = mk(1,  0,  0,  0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b01);
    vecs[19] = mk(1,  0,  0,  9, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[20] = mk(1,  0,  0, 11, 1, 2'b00, 1,  0, 0, 1, 1, 2'b00, 2'b00);
    vecs[21] = mk(1, 11,  9,  0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[22] = mk(1,  0,  0,  0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b01);
    vecs[23] = mk(1,  0,  0, 12, 1, 2'b01, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[24] = mk(1, 12,  0, 13, 1, 2'b00, 1,  0, 0, 1, 1, 2'b00, 2'b00);
    vecs[25] = mk(1,  0,  0,  0, 0, 2'b00, 1,  0, 0, 1, 1, 2'b00, 2'b00);
    vecs[26] = mk(1, 12, 13,  0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[27] = mk(1,  0,  0,  0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[28] = mk(1,  0,  0, 14, 1, 2'b01, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[29] = mk(1, 14,  0,  1, 1, 2'b00, 0,  1, 1, 0, 1, 2'b00, 2'b00);
    vecs[30] = mk(0, 14,  0,  1, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[31] = mk(1, 14,  0,  1, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[32] = mk(1,  0,  0,  0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00);

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i], i);
    end

    // Back-to-back redirects with arbitrary decode contents: every cycle flushes, never stalls
    step(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00), 100);
    for (int i = 0; i < 4; i++) begin
      step(mk(1, int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(31)),
              1'($urandom_range(1)), 2'($urandom_range(3)), 1,
              0, 0, 1, 1, 2'b00, 2'b00), 101 + i);
    end
    step(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00), 105);

    chk("scoreboard_drained", 106, 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
